// File: rtl/rs_flag_bank_if.sv
// rtl/rs_flag_bank_if.sv - set/clear/mask request bundle and flag status outputs of rs_flag_bank
interface rs_flag_bank_if #(
  parameter int N_CH = 8
);
  localparam int CW = $clog2(N_CH + 1);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] s;
  logic [N_CH-1:0] r;
  logic            clr_all;
  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] q;
  logic [N_CH-1:0] ovf;
  logic            irq;
  logic [CW-1:0]   pend_cnt;
  logic [IW-1:0]   first_id;
  logic            first_valid;

  modport master (
    output s, r, clr_all, mask,
    input  q, ovf, irq, pend_cnt, first_id, first_valid
  );

  modport slave (
    input  s, r, clr_all, mask,
    output q, ovf, irq, pend_cnt, first_id, first_valid
  );
endinterface

// File: rtl/rs_flag_bank.sv
// rtl/rs_flag_bank.sv - bank of sticky set/clear flags with overflow, masked irq, pending count and priority encoder
module rs_flag_bank #(
  parameter int N_CH         = 8,
  parameter int SET_PRIORITY = 1,
  parameter int EDGE_MODE    = 0
) (
  input logic           clk,
  input logic           reset,
  rs_flag_bank_if.slave bus
);
  localparam int CW = $clog2(N_CH + 1);
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [N_CH-1:0] s_d;
  logic [N_CH-1:0] s_evt;
  logic [N_CH-1:0] q_r, q_next;
  logic [N_CH-1:0] ovf_r, ovf_next;
  logic            irq_r, irq_next;
  logic [CW-1:0]   pend_r, pend_next;
  logic [IW-1:0]   fid_r, fid_next;

  assign s_evt = (EDGE_MODE != 0) ? (bus.s & ~s_d) : bus.s;

  always_comb begin
    q_next   = q_r;
    ovf_next = ovf_r;
    for (int i = 0; i < N_CH; i++) begin
      if (bus.clr_all)
        q_next[i] = 1'b0;
      else if (s_evt[i] && bus.r[i])
        q_next[i] = (SET_PRIORITY != 0);
      else if (s_evt[i])
        q_next[i] = 1'b1;
      else if (bus.r[i])
        q_next[i] = 1'b0;

      // A clear in the same cycle always cancels overflow, whichever side wins q.
      if (bus.clr_all || bus.r[i])
        ovf_next[i] = 1'b0;
      else if (s_evt[i] && q_r[i])
        ovf_next[i] = 1'b1;
    end
  end

  // Status outputs are derived from q_next so they land on the same edge as q.
  always_comb begin
    irq_next  = |(q_next & ~bus.mask);
    pend_next = '0;
    fid_next  = '0;
    for (int i = 0; i < N_CH; i++)
      pend_next = pend_next + CW'(q_next[i]);
    for (int i = N_CH - 1; i >= 0; i--)
      if (q_next[i] && !bus.mask[i])
        fid_next = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_d    <= '0;
      q_r    <= '0;
      ovf_r  <= '0;
      irq_r  <= 1'b0;
      pend_r <= '0;
      fid_r  <= '0;
    end else begin
      s_d    <= bus.s;
      q_r    <= q_next;
      ovf_r  <= ovf_next;
      irq_r  <= irq_next;
      pend_r <= pend_next;
      fid_r  <= fid_next;
    end
  end

  assign bus.q           = q_r;
  assign bus.ovf         = ovf_r;
  assign bus.irq         = irq_r;
  assign bus.pend_cnt    = pend_r;
  assign bus.first_id    = fid_r;
  assign bus.first_valid = irq_r;
endmodule
